// File: rtl/m_pipe_ctrl.sv
// m_pipe_ctrl: hazard and sequencing controller for the 5-stage m_proc11 pipeline.
// Detects RAW hazards between the ID sources and the EX/ME/WB producers. Drives the
// EX forwarding selects, the ID-stage WB bypass, the load-use and branch stalls, and
// the HALT drain sequence. Also keeps a saturating count of stall cycles.
module m_pipe_ctrl #(
  parameter bit FWD_EN    = 1'b1,
  parameter int DRAIN_CYC = 3,
  parameter int CW        = 32
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic [5:0]    w_id_op,
  input  logic [4:0]    w_id_rs,
  input  logic [4:0]    w_id_rt,
  input  logic [5:0]    w_ex_op,
  input  logic [4:0]    w_ex_rd2,
  input  logic          w_ex_w,
  input  logic [5:0]    w_me_op,
  input  logic [4:0]    w_me_rd2,
  input  logic          w_me_w,
  input  logic [4:0]    w_wb_rd2,
  input  logic          w_wb_w,
  output logic          w_stall,
  output logic          w_bubble,
  output logic          w_flush,
  output logic          w_byp_rs,
  output logic          w_byp_rt,
  output logic [1:0]    r_fwd_rs,
  output logic [1:0]    r_fwd_rt,
  output logic [1:0]    r_state,
  output logic          r_halt,
  output logic [CW-1:0] r_stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h11;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_STALL  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRN_LAST = DW'(DRAIN_CYC - 1);

  // A producer feeds a source only if it writes, targets a real register, and names it.
  function automatic logic src_match(input logic p_w, input logic [4:0] p_rd2,
                                     input logic [4:0] src);
    return p_w && (p_rd2 != 5'd0) && (p_rd2 == src);
  endfunction

  // Performance counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic          uses_rt;
  logic          is_branch;
  logic          ex_rs_hit;
  logic          ex_rt_hit;
  logic          me_rs_hit;
  logic          me_rt_hit;
  logic          near_hit;
  logic          load_use;
  logic          branch_haz;
  logic          nofwd_haz;
  logic          stall_cond;
  logic          running;
  logic [1:0]    fwd_rs_id;
  logic [1:0]    fwd_rt_id;
  logic [1:0]    nxt_state;
  logic [DW-1:0] drn_cnt;
  logic [DW-1:0] nxt_drn;

  // The ME opcode carries no hazard information; it stays on the port list for
  // interface symmetry with the other stage taps.
  logic unused_me_op;
  assign unused_me_op = ^w_me_op;

  assign is_branch = (w_id_op == OP_BEQ) || (w_id_op == OP_BNE);
  assign uses_rt   = (w_id_op == OP_RTYPE) || (w_id_op == OP_SW) || is_branch;

  assign ex_rs_hit = src_match(w_ex_w, w_ex_rd2, w_id_rs);
  assign ex_rt_hit = uses_rt && src_match(w_ex_w, w_ex_rd2, w_id_rt);
  assign me_rs_hit = src_match(w_me_w, w_me_rd2, w_id_rs);
  assign me_rt_hit = uses_rt && src_match(w_me_w, w_me_rd2, w_id_rt);
  assign near_hit  = ex_rs_hit || ex_rt_hit || me_rs_hit || me_rt_hit;

  // Loads deliver data only after ME; branches resolve in ID without EX forwarding.
  assign load_use   = (w_ex_op == OP_LW) && (ex_rs_hit || ex_rt_hit);
  assign branch_haz = is_branch && near_hit;
  assign nofwd_haz  = !FWD_EN && near_hit;
  assign stall_cond = load_use || branch_haz || nofwd_haz;

  assign running  = (r_state == S_RUN) || (r_state == S_STALL);
  assign w_stall  = running ? stall_cond : 1'b1;
  assign w_bubble = running ? stall_cond : 1'b1;
  assign w_flush  = !running;

  // The regfile write and the ID read share a cycle, so WB producers bypass into ID.
  assign w_byp_rs = src_match(w_wb_w, w_wb_rd2, w_id_rs);
  assign w_byp_rt = src_match(w_wb_w, w_wb_rd2, w_id_rt);

  // The nearer producer (EX, arriving in ME next cycle) wins over ME.
  assign fwd_rs_id = (FWD_EN && ex_rs_hit) ? 2'b01 :
                     (FWD_EN && me_rs_hit) ? 2'b10 : 2'b00;
  assign fwd_rt_id = (FWD_EN && ex_rt_hit) ? 2'b01 :
                     (FWD_EN && me_rt_hit) ? 2'b10 : 2'b00;

  // Next-state logic: HALTED > DRAIN > stall > RUN.
  always_comb begin
    nxt_state = r_state;
    nxt_drn   = drn_cnt;
    case (r_state)
      S_RUN, S_STALL: begin
        nxt_drn = '0;
        if (stall_cond)              nxt_state = S_STALL;
        else if (w_id_op == OP_HALT) nxt_state = S_DRAIN;
        else                         nxt_state = S_RUN;
      end
      S_DRAIN: begin
        if (drn_cnt == DRN_LAST) begin
          nxt_state = S_HALTED;
          nxt_drn   = '0;
        end else begin
          nxt_drn = drn_cnt + DW'(1);
        end
      end
      default: begin
        nxt_state = S_HALTED;
        nxt_drn   = '0;
      end
    endcase
  end

  // FSM state, drain counter and sticky halt flag.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= S_RUN;
      drn_cnt <= '0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= nxt_state;
      drn_cnt <= nxt_drn;
      r_halt  <= r_halt || (nxt_state == S_HALTED);
    end
  end

  // Forward selects follow the instruction into EX; a bubble reads nothing, so 00.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_fwd_rs <= 2'b00;
      r_fwd_rt <= 2'b00;
    end else if (running && !stall_cond) begin
      r_fwd_rs <= fwd_rs_id;
      r_fwd_rt <= fwd_rt_id;
    end else begin
      r_fwd_rs <= 2'b00;
      r_fwd_rt <= 2'b00;
    end
  end

  // Stall-cycle counter; drain and halt cycles are not hazard stalls and are excluded.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_stall_cnt <= '0;
    end else if (running && stall_cond) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

endmodule
